bcd_serial_collector: RTL and testbench

- Downstream stage of the serial Excess-3-to-BCD converter.
- Consumes the converter's serial BCD output (4-bit digits, LSB first) and reassembles each digit in parallel.
- Flags non-BCD codes and accumulates DIGITS consecutive valid digits into a packed multi-digit number for later stages (display/compare).

---
 rtl/bcd_serial_collector_if.sv | 26 ++
 rtl/bcd_serial_collector.sv | 114 +++++++++++
 tb/tb_bcd_serial_collector.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_collector_if.sv
// Serial BCD bit stream in, reassembled digit and packed number out.
interface bcd_serial_collector_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  Bit_In;
  logic                  Bit_Valid;
  logic [1:0]            Phase;
  logic [3:0]            Digit;
  logic                  Digit_Valid;
  logic                  Digit_Err;
  logic                  Err_Sticky;
  logic [4*DIGITS-1:0]   Number;
  logic                  Number_Valid;

  // Upstream side: drives the serial bits, observes the collector.
  modport master (
    output Bit_In, Bit_Valid,
    input  Phase, Digit, Digit_Valid, Digit_Err, Err_Sticky, Number, Number_Valid
  );

  // Collector side.
  modport slave (
    input  Bit_In, Bit_Valid,
    output Phase, Digit, Digit_Valid, Digit_Err, Err_Sticky, Number, Number_Valid
  );
endinterface

// File: rtl/bcd_serial_collector.sv
// Collects LSB-first serial BCD digits, flags non-BCD codes and packs
// DIGITS consecutive valid digits into a multi-digit number.
module bcd_serial_collector #(
  parameter int unsigned DIGITS = 4
) (
  input logic                   Clk,
  input logic                   Rst,
  bcd_serial_collector_if.slave bus_io
);

  localparam int unsigned NumW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {StB0, StB1, StB2, StB3} phase_e;

  phase_e            phase_q, phase_d;
  logic [2:0]        hold_q, hold_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              digit_err_q, digit_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [NumW-1:0]   number_q, number_d;
  logic              number_valid_q, number_valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        comp_digit;

  // Digit as it completes on the B3 accepting edge.
  assign comp_digit = {bus_io.Bit_In, hold_q};

  // Next-state: bit capture, digit completion, validity check and packing.
  always_comb begin
    phase_d        = phase_q;
    hold_d         = hold_q;
    digit_d        = digit_q;
    digit_valid_d  = 1'b0;
    digit_err_d    = 1'b0;
    err_sticky_d   = err_sticky_q;
    number_d       = number_q;
    number_valid_d = 1'b0;
    cnt_d          = cnt_q;

    if (bus_io.Bit_Valid) begin
      unique case (phase_q)
        StB0: begin
          hold_d[0] = bus_io.Bit_In;
          phase_d   = StB1;
        end
        StB1: begin
          hold_d[1] = bus_io.Bit_In;
          phase_d   = StB2;
        end
        StB2: begin
          hold_d[2] = bus_io.Bit_In;
          phase_d   = StB3;
        end
        StB3: begin
          phase_d       = StB0;
          digit_d       = comp_digit;
          digit_valid_d = 1'b1;
          if (comp_digit > 4'd9) begin
            // A bad code breaks the run of consecutive digits.
            digit_err_d  = 1'b1;
            err_sticky_d = 1'b1;
            cnt_d        = '0;
          end else begin
            // Truncating the concatenation drops the oldest digit.
            number_d = NumW'({number_q, comp_digit});
            if (cnt_q == CntW'(DIGITS - 1)) begin
              number_valid_d = 1'b1;
              cnt_d          = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: phase_d = StB0;
      endcase
    end
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      phase_q        <= StB0;
      hold_q         <= '0;
      digit_q        <= '0;
      digit_valid_q  <= 1'b0;
      digit_err_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      number_q       <= '0;
      number_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      phase_q        <= phase_d;
      hold_q         <= hold_d;
      digit_q        <= digit_d;
      digit_valid_q  <= digit_valid_d;
      digit_err_q    <= digit_err_d;
      err_sticky_q   <= err_sticky_d;
      number_q       <= number_d;
      number_valid_q <= number_valid_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus_io.Phase        = phase_q;
  assign bus_io.Digit        = digit_q;
  assign bus_io.Digit_Valid  = digit_valid_q;
  assign bus_io.Digit_Err    = digit_err_q;
  assign bus_io.Err_Sticky   = err_sticky_q;
  assign bus_io.Number       = number_q;
  assign bus_io.Number_Valid = number_valid_q;

endmodule

// File: tb/tb_bcd_serial_collector.sv
// Directed bench for bcd_serial_collector with DIGITS=4.
module tb_bcd_serial_collector;

  localparam int unsigned DIGITS = 4;

  logic Clk;
  logic Rst;
  int   n_checks;
  int   n_fail;

  bcd_serial_collector_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_collector #(.DIGITS(DIGITS)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .bus_io (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one accepted bit; returns #1 after the accepting edge.
  task automatic send_bit(input logic b);
    @(negedge Clk);
    bus.Bit_Valid = 1'b1;
    bus.Bit_In    = b;
    @(posedge Clk);
    #1;
    bus.Bit_Valid = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
  endtask

  task automatic idle_cycle();
    @(negedge Clk);
    bus.Bit_Valid = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst           = 1'b0;
    bus.Bit_Valid = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst           = 1'b0;
    bus.Bit_Valid = 1'b1;
    bus.Bit_In    = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (bus.Phase !== 2'd0) begin
      n_fail++; $display("FAIL reset_phase got %0d want 0", bus.Phase);
    end
    n_checks++;
    if ({bus.Digit, bus.Digit_Valid, bus.Digit_Err, bus.Err_Sticky, bus.Number_Valid} !== 8'h00)
    begin
      n_fail++; $display("FAIL reset_digit_flags got %h/%b%b%b%b want 0", bus.Digit,
                         bus.Digit_Valid, bus.Digit_Err, bus.Err_Sticky, bus.Number_Valid);
    end
    n_checks++;
    if (bus.Number !== 16'h0000) begin
      n_fail++; $display("FAIL reset_number got %h want 0000", bus.Number);
    end
    @(negedge Clk);
    Rst           = 1'b1;
    bus.Bit_Valid = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.Phase !== 2'(i)) begin
        n_fail++; $display("FAIL phase_adv_%0d got %0d want %0d", i, bus.Phase, i);
      end
      send_bit(1'b0);
    end
    n_checks++;
    if (bus.Phase !== 2'd0) begin
      n_fail++; $display("FAIL phase_wrap got %0d want 0", bus.Phase);
    end
  endtask

  task automatic test_single_digit();
    do_reset();
    send_digit(4'd5);
    n_checks++;
    if (bus.Digit !== 4'b0101 || bus.Digit_Valid !== 1'b1 || bus.Digit_Err !== 1'b0) begin
      n_fail++; $display("FAIL five_digit got %b v%b e%b want 0101 v1 e0", bus.Digit,
                         bus.Digit_Valid, bus.Digit_Err);
    end
    n_checks++;
    if (bus.Number !== 16'h0005 || bus.Number_Valid !== 1'b0) begin
      n_fail++; $display("FAIL five_number got %h nv%b want 0005 nv0", bus.Number,
                         bus.Number_Valid);
    end
    idle_cycle();
    n_checks++;
    if (bus.Digit_Valid !== 1'b0 || bus.Digit !== 4'b0101) begin
      n_fail++; $display("FAIL five_pulse_end got v%b %b want v0 0101", bus.Digit_Valid,
                         bus.Digit);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] digs [4];
    digs = '{4'd1, 4'd2, 4'd3, 4'd4};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_digit(digs[k]);
      n_checks++;
      if (bus.Digit_Valid !== 1'b1 || bus.Number_Valid !== (k == 3)) begin
        n_fail++; $display("FAIL b2b_pulse_%0d got dv%b nv%b want dv1 nv%0d", k,
                           bus.Digit_Valid, bus.Number_Valid, (k == 3));
      end
    end
    n_checks++;
    if (bus.Number !== 16'h1234) begin
      n_fail++; $display("FAIL b2b_number got %h want 1234", bus.Number);
    end
    idle_cycle();
    n_checks++;
    if (bus.Number_Valid !== 1'b0 || bus.Number !== 16'h1234) begin
      n_fail++; $display("FAIL b2b_hold got nv%b %h want nv0 1234", bus.Number_Valid, bus.Number);
    end
  endtask

  task automatic test_invalid_digit();
    logic [3:0] digs [4];
    digs = '{4'd9, 4'd8, 4'd7, 4'd6};
    do_reset();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd12);
    n_checks++;
    if (bus.Digit_Err !== 1'b1 || bus.Err_Sticky !== 1'b1 || bus.Digit_Valid !== 1'b1 ||
        bus.Digit !== 4'd12) begin
      n_fail++; $display("FAIL err_flags got e%b s%b v%b d%0d want e1 s1 v1 d12", bus.Digit_Err,
                         bus.Err_Sticky, bus.Digit_Valid, bus.Digit);
    end
    n_checks++;
    if (bus.Number !== 16'h0012 || bus.Number_Valid !== 1'b0) begin
      n_fail++; $display("FAIL err_number got %h nv%b want 0012 nv0", bus.Number,
                         bus.Number_Valid);
    end
    idle_cycle();
    n_checks++;
    if (bus.Digit_Err !== 1'b0 || bus.Err_Sticky !== 1'b1) begin
      n_fail++; $display("FAIL err_pulse_end got e%b s%b want e0 s1", bus.Digit_Err,
                         bus.Err_Sticky);
    end
    for (int k = 0; k < 4; k++) begin
      send_digit(digs[k]);
      n_checks++;
      if (bus.Number_Valid !== (k == 3) || bus.Digit_Err !== 1'b0) begin
        n_fail++; $display("FAIL err_recover_%0d got nv%b e%b want nv%0d e0", k,
                           bus.Number_Valid, bus.Digit_Err, (k == 3));
      end
    end
    n_checks++;
    if (bus.Number !== 16'h9876 || bus.Err_Sticky !== 1'b1) begin
      n_fail++; $display("FAIL err_final got %h s%b want 9876 s1", bus.Number, bus.Err_Sticky);
    end
    do_reset();
    n_checks++;
    if (bus.Err_Sticky !== 1'b0 || bus.Number !== 16'h0000) begin
      n_fail++; $display("FAIL err_cleared got s%b %h want s0 0000", bus.Err_Sticky, bus.Number);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] d;
    int         pulses;
    d      = 4'd7;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_bit(d[i]);
      if (bus.Digit_Valid === 1'b1) pulses++;
      for (int g = 0; g < 3; g++) begin
        idle_cycle();
        if (bus.Digit_Valid === 1'b1) pulses++;
        n_checks++;
        if (bus.Phase !== 2'((i + 1) % 4)) begin
          n_fail++; $display("FAIL gap_phase_%0d_%0d got %0d want %0d", i, g, bus.Phase,
                             (i + 1) % 4);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL gap_pulses got %0d want 1", pulses);
    end
    n_checks++;
    if (bus.Digit !== 4'b0111 || bus.Digit_Err !== 1'b0 || bus.Number !== 16'h0007) begin
      n_fail++; $display("FAIL gap_digit got %b e%b %h want 0111 e0 0007", bus.Digit,
                         bus.Digit_Err, bus.Number);
    end
  endtask

  task automatic test_reset_mid_digit();
    do_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge Clk);
    Rst           = 1'b0;
    bus.Bit_Valid = 1'b1;
    bus.Bit_In    = 1'b1;
    @(posedge Clk);
    #1;
    Rst           = 1'b1;
    bus.Bit_Valid = 1'b0;
    n_checks++;
    if (bus.Phase !== 2'd0) begin
      n_fail++; $display("FAIL midrst_phase got %0d want 0", bus.Phase);
    end
    send_digit(4'd3);
    n_checks++;
    if (bus.Digit !== 4'b0011 || bus.Digit_Valid !== 1'b1 || bus.Phase !== 2'd0) begin
      n_fail++; $display("FAIL midrst_digit got %b v%b p%0d want 0011 v1 p0", bus.Digit,
                         bus.Digit_Valid, bus.Phase);
    end
    n_checks++;
    if (bus.Number !== 16'h0003) begin
      n_fail++; $display("FAIL midrst_number got %h want 0003", bus.Number);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    Rst           = 1'b0;
    bus.Bit_Valid = 1'b0;
    bus.Bit_In    = 1'b0;
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_invalid_digit();
    test_gaps();
    test_reset_mid_digit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
